sha_batch_scheduler: RTL and testbench

Sequences a bank of parallel SHA lanes for the miner. Each batch it issues staggered per-lane begin pulses and collects the lanes' completion flags. It then scans the lanes' results one per cycle through an external target comparator and advances the nonce base by one batch width. It terminates on a hit, on nonce-space exhaustion, on a watchdog timeout, or on abort. It sits between the Avalon-facing control and status logic and the generated SHA lanes.

---
 rtl/sha_sched_pkg.sv | 27 ++
 rtl/lane_done_tracker.sv | 30 +++
 rtl/sha_batch_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_sha_batch_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_sched_pkg.sv
// Shared state type, widths and nonce-space helper for sha_batch_scheduler.
// The SHA_SCHED_PERF_CNT_EN build option only changes the top module.
package sha_sched_pkg;

  localparam int NONCE_W = 32;
  localparam int EXT_W   = NONCE_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    SCAN,
    ADVANCE,
    FINISH
  } sched_state_t;

  // True when a further full batch after base would run past 2^32-1.
  function automatic logic nonceExhausted(
    input logic [NONCE_W-1:0] base,
    input int unsigned        lanes
  );
    logic [EXT_W-1:0] lastNext;
    lastNext = {1'b0, base} + EXT_W'(2 * lanes - 1);
    return lastNext > {1'b0, {NONCE_W{1'b1}}};
  endfunction

endpackage

// File: rtl/lane_done_tracker.sv
// Sticky per-lane completion mask for one batch of SHA lanes.
// all_done includes completions arriving in the current cycle.
module lane_done_tracker
  import sha_sched_pkg::*;
#(
  parameter int NUM_LANES = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [NUM_LANES-1:0] lane_done,
  output logic                 all_done
);

  logic [NUM_LANES-1:0] mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (clear) begin
      mask <= '0;
    end else if (en) begin
      mask <= mask | lane_done;
    end
  end

  assign all_done = &(mask | lane_done);

endmodule

// File: rtl/sha_batch_scheduler.sv
// Batch sequencer for parallel SHA lanes: launch, wait, scan, advance.
// Define SHA_SCHED_PERF_CNT_EN to add the 48-bit hash_count port.
module sha_batch_scheduler
  import sha_sched_pkg::*;
#(
  parameter int           NUM_LANES      = 10,
  parameter int           LANE_W         = 4,
  parameter logic [31:0]  NONCE_START    = 32'h0,
  parameter int           TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_LANES-1:0] lane_done,
  input  logic                 lane_hit,
  output logic [NUM_LANES-1:0] lane_begin,
  output logic [LANE_W-1:0]    lane_sel,
  output logic [NONCE_W-1:0]   nonce_base,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 error,
  output logic [NONCE_W-1:0]   found_nonce
`ifdef SHA_SCHED_PERF_CNT_EN
  ,
  output logic [47:0]          hash_count
`endif
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + NUM_LANES + 1);
  localparam int LIDX_W = $clog2(NUM_LANES);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [LIDX_W-1:0] LAST_LAUNCH = LIDX_W'(NUM_LANES - 1);
  localparam logic [NUM_LANES-1:0] LANE_ONE =
    {{(NUM_LANES-1){1'b0}}, 1'b1};

  sched_state_t state, nextState;

  logic [LIDX_W-1:0] launchIdx;
  logic [WDOG_W-1:0] wdog;
  logic allDone;
  logic accept;
  logic tracking;
  logic timedOut;
  logic hitNow;
  logic enterLaunch;

  lane_done_tracker #(
    .NUM_LANES(NUM_LANES)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (enterLaunch),
    .en       (tracking),
    .lane_done(lane_done),
    .all_done (allDone)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    lane_begin = '0;
    accept     = 1'b0;
    tracking   = 1'b0;
    timedOut   = 1'b0;
    hitNow     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = LAUNCH;
        end
      end
      LAUNCH: begin
        tracking   = 1'b1;
        lane_begin = LANE_ONE << launchIdx;
        if (launchIdx == LAST_LAUNCH) begin
          nextState = WAIT;
        end
      end
      WAIT: begin
        tracking = 1'b1;
        // Completion beats a watchdog expiry landing on the same cycle.
        if (allDone) begin
          nextState = SCAN;
        end else if (wdog + 1'b1 >= WDOG_LIMIT) begin
          timedOut  = 1'b1;
          nextState = FINISH;
        end
      end
      SCAN: begin
        if (lane_hit) begin
          hitNow    = 1'b1;
          nextState = FINISH;
        end else if (lane_sel == LAST_LANE) begin
          nextState = ADVANCE;
        end
      end
      ADVANCE: begin
        nextState = nonceExhausted(nonce_base, NUM_LANES) ? FINISH : LAUNCH;
      end
      FINISH: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
    if (abort) begin
      nextState  = IDLE;
      lane_begin = '0;
      accept     = 1'b0;
      timedOut   = 1'b0;
      hitNow     = 1'b0;
    end
  end

  assign enterLaunch = (nextState == LAUNCH) && (state != LAUNCH);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      launchIdx   <= '0;
      wdog        <= '0;
      lane_sel    <= '0;
      nonce_base  <= NONCE_START;
      done        <= 1'b0;
      found       <= 1'b0;
      error       <= 1'b0;
      found_nonce <= '0;
    end else begin
      if (state == LAUNCH && nextState == LAUNCH) begin
        launchIdx <= launchIdx + 1'b1;
      end else begin
        launchIdx <= '0;
      end

      if (enterLaunch) begin
        wdog <= '0;
      end else if (tracking) begin
        wdog <= wdog + 1'b1;
      end

      if (state == SCAN && nextState == SCAN) begin
        lane_sel <= lane_sel + 1'b1;
      end else begin
        lane_sel <= '0;
      end

      if (accept) begin
        nonce_base <= NONCE_START;
      end else if (state == ADVANCE && nextState == LAUNCH) begin
        nonce_base <= nonce_base + NONCE_W'(NUM_LANES);
      end

      if (abort || accept) begin
        done        <= 1'b0;
        found       <= 1'b0;
        error       <= 1'b0;
        found_nonce <= '0;
      end else if (nextState == FINISH) begin
        done  <= 1'b1;
        found <= hitNow;
        error <= timedOut;
        if (hitNow) begin
          found_nonce <= nonce_base
            + {{(NONCE_W-LANE_W){1'b0}}, lane_sel};
        end
      end
    end
  end

`ifdef SHA_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hash_count <= '0;
    end else if (accept) begin
      hash_count <= '0;
    end else if (state == SCAN && !(&hash_count)) begin
      hash_count <= hash_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sha_batch_scheduler.sv
// Randomised self-checking bench for sha_batch_scheduler.
// Expected per-cycle traces come from a batch-level timeline model.
module tb_sha_batch_scheduler;

  localparam int          N         = 4;
  localparam int          LW        = 2;
  localparam logic [31:0] NSTART    = 32'hFFFF_FFE8;
  localparam int          TMO       = 16;
  localparam int          DEPTH     = 1024;
  localparam int          IDLE_TAIL = 6;
  localparam logic [N-1:0] ONE      = 1;

  typedef struct packed {
    logic [N-1:0]  beg;
    logic [LW-1:0] sel;
    logic [31:0]   base;
    logic          busy;
    logic          done;
    logic          found;
    logic          err;
    logic [31:0]   fnon;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [N-1:0]  lane_done;
  logic          lane_hit;
  logic [N-1:0]  lane_begin;
  logic [LW-1:0] lane_sel;
  logic [31:0]   nonce_base;
  logic          busy;
  logic          done;
  logic          found;
  logic          error;
  logic [31:0]   found_nonce;
`ifdef SHA_SCHED_PERF_CNT_EN
  logic [47:0]   hash_count;
`endif

  exp_t         ex  [DEPTH];
  logic [N-1:0] drv [DEPTH];
  int           abortAt;
  int           endCyc;
  logic         tgtEn;
  logic [31:0]  tgt;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  // Target comparator: hit when the addressed lane's nonce is the golden one.
  assign lane_hit = tgtEn && ((nonce_base + 32'(lane_sel)) == tgt);

  sha_batch_scheduler #(
    .NUM_LANES     (N),
    .LANE_W        (LW),
    .NONCE_START   (NSTART),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .lane_done  (lane_done),
    .lane_hit   (lane_hit),
    .lane_begin (lane_begin),
    .lane_sel   (lane_sel),
    .nonce_base (nonce_base),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .error      (error),
    .found_nonce(found_nonce)
`ifdef SHA_SCHED_PERF_CNT_EN
    ,
    .hash_count (hash_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic chkReset(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_beg"}, lane_begin, 0);
    chk({p, "_sel"}, lane_sel, 0);
    chk({p, "_base"}, nonce_base, NSTART);
    chk({p, "_done"}, done, 0);
    chk({p, "_found"}, found, 0);
    chk({p, "_err"}, error, 0);
    chk({p, "_fn"}, found_nonce, 0);
  endtask

  function automatic exp_t rec(input logic [N-1:0] b, input int s,
                               input logic [31:0] base, input logic bz);
    exp_t r;
    r = '0;
    r.beg  = b;
    r.sel  = LW'(s);
    r.base = base;
    r.busy = bz;
    return r;
  endfunction

  // Builds the expected timeline of one search, batch by batch.
  task automatic build(input logic en, input logic [31:0] tv,
                       input int stuckB, input int edgeB,
                       input logic abortHit, input int abortRnd);
    logic [31:0] base;
    logic        fnd, er, never;
    logic [31:0] fn;
    int          t, b, fin, c, d;
    base = NSTART;
    fnd = 0; er = 0; fn = '0;
    t = 0; b = 0; fin = -1;
    tgtEn = en; tgt = tv; abortAt = -1;
    for (int i = 0; i < DEPTH; i++) begin
      ex[i] = '0;
      drv[i] = '0;
    end
    while (fin < 0) begin
      c = t + N;
      never = 0;
      for (int i = 0; i < N; i++) begin
        if (b == stuckB && i == N - 1) begin
          never = 1;
        end else begin
          d = t + i + ((b == edgeB && i == N - 1) ? TMO - N
                       : int'($urandom_range(1, 8)));
          drv[d][i] = 1'b1;
          if (d > c) c = d;
        end
      end
      if (never || c - t >= TMO) begin
        for (int k = 0; k < TMO; k++)
          ex[t+k] = rec(k < N ? ONE << k : '0, 0, base, 1);
        fin = t + TMO;
        er = 1;
      end else begin
        for (int k = t; k <= c; k++)
          ex[k] = rec(k - t < N ? ONE << (k - t) : '0, 0, base, 1);
        for (int j = 0; j < N && fin < 0; j++) begin
          ex[c+1+j] = rec('0, j, base, 1);
          if (en && (base + 32'(j)) == tv) begin
            fin = c + 2 + j;
            fnd = 1;
            fn = tv;
            if (abortHit) abortAt = c + 1 + j;
          end
        end
        if (fin < 0) begin
          ex[c+1+N] = rec('0, 0, base, 1);
          if (64'(base) + 2 * N - 1 > 64'hFFFF_FFFF) begin
            fin = c + 2 + N;
          end else begin
            base += N;
            t = c + 2 + N;
            b++;
          end
        end
      end
    end
    ex[fin] = rec('0, 0, base, 1);
    ex[fin].done = 1;
    ex[fin].found = fnd;
    ex[fin].err = er;
    ex[fin].fnon = fn;
    endCyc = fin + 1;
    for (int k = endCyc; k < endCyc + IDLE_TAIL; k++) begin
      ex[k] = ex[fin];
      ex[k].busy = 0;
    end
    if (abortRnd >= 0) abortAt = (abortRnd > fin) ? fin : abortRnd;
    if (abortAt >= 0) begin
      ex[abortAt].beg = '0;
      endCyc = abortAt + 1;
      for (int k = endCyc; k < endCyc + IDLE_TAIL; k++)
        ex[k] = rec('0, 0, ex[abortAt].base, 0);
    end
    for (int k = endCyc; k < endCyc + IDLE_TAIL; k++)
      drv[k] = N'($urandom);
  endtask

  task automatic run(input logic hold);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < endCyc + IDLE_TAIL; t++) begin
      lane_done = drv[t];
      abort = (t == abortAt);
      start = hold && (t < endCyc);
      @(negedge clk);
      chk($sformatf("beg@%0d", t), lane_begin, ex[t].beg);
      chk($sformatf("sel@%0d", t), lane_sel, ex[t].sel);
      chk($sformatf("base@%0d", t), nonce_base, ex[t].base);
      chk($sformatf("busy@%0d", t), busy, ex[t].busy);
      chk($sformatf("done@%0d", t), done, ex[t].done);
      chk($sformatf("found@%0d", t), found, ex[t].found);
      chk($sformatf("err@%0d", t), error, ex[t].err);
      chk($sformatf("fn@%0d", t), found_nonce, ex[t].fnon);
      @(posedge clk); #1;
    end
    lane_done = '0;
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    lane_done = '0;
    tgtEn = 1'b0;
    tgt = '0;
    #1;
    chkReset("rst0");
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    build(1, NSTART + 2, -1, -1, 0, -1);
    run(0);
    build(1, NSTART + 12, -1, -1, 0, -1);
    run(0);
    build(0, 0, -1, 2, 0, -1);
    run(1);
    build(0, 0, 0, -1, 0, -1);
    run(0);

    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_done", done, 0);
    chk("sa_err", error, 0);
    chk("sa_beg", lane_begin, 0);
    @(posedge clk); #1;
    chk("sa_busy2", busy, 0);

    build(1, NSTART + 1, -1, -1, 1, -1);
    run(0);

    tgtEn = 1'b0;
    lane_done = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    chk("w_busy", busy, 1);
    rst = 1'b1;
    #1;
    chkReset("rstw");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < 12; r++) begin
      build(1'($urandom_range(0, 1)),
            NSTART + $urandom_range(0, 23),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1,
            0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1);
      run(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
